// File: rtl/div_pkg.sv
// Shared divider types: FSM state encoding and default operand width.
// Imported by the divider and the execute-stage stall logic.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  localparam int DIV_WIDTH = 64;

endpackage

// File: rtl/cla_sub.sv
// N-bit subtractor a - b on a carry-lookahead adder (b inverted, cin=1).
// 4-bit groups feed a group-level lookahead unit; borrow = ~cout.
module cla_sub #(
  parameter int N = 65
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int NB = (N + 3) / 4;
  localparam int NP = NB * 4;

  logic [NP-1:0] x, y, g, p, c;
  logic [NB-1:0] bg, bp;
  logic [NB:0]   bc;
  logic          unused_hi;

  always_comb begin
    x = NP'(a);
    y = NP'(~b);
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < NB; k++) begin
      bp[k] = &p[4*k +: 4];
      bg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (&p[4*k+2 +: 2] & g[4*k+1])
            | (&p[4*k+1 +: 3] & g[4*k]);
    end
    bc[0] = 1'b1;
    for (int k = 0; k < NB; k++) begin
      bc[k+1] = bg[k] | (bp[k] & bc[k]);
    end
    c = '0;
    for (int k = 0; k < NB; k++) begin
      c[4*k] = bc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    diff   = p[N-1:0] ^ c[N-1:0];
    borrow = ~c[N];
  end

  assign unused_hi = ^{c[NP-1:N+1], bc[NB]};

endmodule

// File: rtl/divider_seq.sv
// Radix-2 restoring divider, one quotient bit per cycle.
// Signed/unsigned, with divide-by-zero and MIN/-1 short-cut results.
module divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t           state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   rq;
  logic [WIDTH-1:0]     dvs;
  logic                 neg_q, neg_r;

  logic [WIDTH:0]       a0, b0, d0, b1, d1;
  logic                 br0, br1;
  logic                 sa, sb;
  logic [WIDTH-1:0]     ad, ab;
  logic                 unused_ok;

  // sub0: |dividend| in IDLE, trial subtract in CALC, -quo in FIX.
  // sub1: |divisor| in IDLE, -rem in FIX.
  always_comb begin
    a0 = '0;
    b0 = '0;
    b1 = '0;
    unique case (state)
      IDLE: begin
        b0 = {1'b0, dividend};
        b1 = {1'b0, divisor};
      end
      CALC: begin
        a0 = rq[2*WIDTH-1:WIDTH-1];
        b0 = {1'b0, dvs};
      end
      FIX: begin
        b0 = {1'b0, rq[WIDTH-1:0]};
        b1 = {1'b0, rq[2*WIDTH-1:WIDTH]};
      end
      default: ;
    endcase
  end

  cla_sub #(.N(WIDTH+1)) u_sub0 (
    .a(a0), .b(b0), .diff(d0), .borrow(br0)
  );

  cla_sub #(.N(WIDTH+1)) u_sub1 (
    .a({(WIDTH+1){1'b0}}), .b(b1), .diff(d1), .borrow(br1)
  );

  assign sa = is_signed & dividend[WIDTH-1];
  assign sb = is_signed & divisor[WIDTH-1];
  assign ad = sa ? d0[WIDTH-1:0] : dividend;
  assign ab = sb ? d1[WIDTH-1:0] : divisor;
  assign unused_ok = ^{d0[WIDTH], d1[WIDTH], br1};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rq        <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            cnt      <= '0;
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else if (is_signed && dividend == MIN
                         && divisor == '1) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= dividend;
              remainder <= '0;
            end else begin
              state <= CALC;
              rq    <= {{WIDTH{1'b0}}, ad};
              dvs   <= ab;
              neg_q <= sa ^ sb;
              neg_r <= sa;
            end
          end
        end
        CALC: begin
          rq <= {br0 ? a0[WIDTH-1:0] : d0[WIDTH-1:0],
                 rq[WIDTH-2:0], ~br0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          quotient  <= neg_q ? d0[WIDTH-1:0] : rq[WIDTH-1:0];
          remainder <= neg_r ? d1[WIDTH-1:0]
                             : rq[2*WIDTH-1:WIDTH];
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed table, multi-cycle corners,
// and random operands checked against a plain-arithmetic model.
module tb_divider_seq;

  localparam int W = 64;
  localparam int NLAT = W + 2;
  localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] N100 = -64'd100;
  localparam logic [W-1:0] N7   = -64'd7;
  localparam logic [W-1:0] N14  = -64'd14;
  localparam logic [W-1:0] N2   = -64'd2;
  localparam logic [W-1:0] N5   = -64'd5;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } res_t;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .is_signed(is_signed), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic sgn, logic [W-1:0] a,
                                 logic [W-1:0] b);
    res_t m;
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    m.dz = 1'b0;
    m.lat = NLAT;
    if (b == '0) begin
      m.q = ONES; m.r = a; m.dz = 1'b1; m.lat = 1;
    end else if (sgn && a == MIN && b == ONES) begin
      m.q = a; m.r = '0; m.lat = 1;
    end else if (sgn) begin
      m.q = sa / sb; m.r = sa % sb;
    end else begin
      m.q = a / b; m.r = a % b;
    end
    return m;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    chk("idle_wait", W'(busy), '0);
  endtask

  task automatic issue(logic sgn, logic [W-1:0] a, logic [W-1:0] b);
    wait_idle;
    is_signed = sgn;
    dividend = a;
    divisor = b;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic collect(output res_t got);
    got.lat = 1;
    while (!done && got.lat < 200) begin
      tick;
      got.lat++;
    end
    got.q = quotient;
    got.r = remainder;
    got.dz = div_zero;
  endtask

  task automatic check_res(string nm, res_t got, res_t exp);
    chk({nm, ".q"}, got.q, exp.q);
    chk({nm, ".r"}, got.r, exp.r);
    chk({nm, ".dz"}, W'(got.dz), W'(exp.dz));
    chk({nm, ".lat"}, W'(got.lat), W'(exp.lat));
  endtask

  vec_t tbl[9];

  initial begin
    res_t got, exp;
    int n;
    logic seen;

    tbl[0] = '{1'b0, 64'd100, 64'd7,  64'd14, 64'd2, 1'b0, NLAT};
    tbl[1] = '{1'b1, N100,    64'd7,  N14,    N2,    1'b0, NLAT};
    tbl[2] = '{1'b1, 64'd100, N7,     N14,    64'd2, 1'b0, NLAT};
    tbl[3] = '{1'b1, N100,    N7,     64'd14, N2,    1'b0, NLAT};
    tbl[4] = '{1'b0, 64'h1234, 64'd0, ONES, 64'h1234, 1'b1, 1};
    tbl[5] = '{1'b1, MIN,     ONES,   MIN,    64'd0, 1'b0, 1};
    tbl[6] = '{1'b0, MIN,     ONES,   64'd0,  MIN,   1'b0, NLAT};
    tbl[7] = '{1'b0, ONES,    64'd1,  ONES,   64'd0, 1'b0, NLAT};
    tbl[8] = '{1'b1, N5,      64'd0,  ONES,   N5,    1'b1, 1};

    repeat (3) tick;
    chk("rst.busy", W'(busy), '0);
    chk("rst.done", W'(done), '0);
    chk("rst.q", quotient, '0);
    chk("rst.r", remainder, '0);
    chk("rst.dz", W'(div_zero), '0);
    reset_n = 1'b1;
    tick;
    chk("post_rst.busy", W'(busy), '0);

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].sgn, tbl[i].a, tbl[i].b);
      collect(got);
      exp.q = tbl[i].q;
      exp.r = tbl[i].r;
      exp.dz = tbl[i].dz;
      exp.lat = tbl[i].lat;
      check_res($sformatf("vec%0d", i), got, exp);
    end

    // start pulsed mid-calculation must be ignored
    issue(1'b0, 64'd1000, 64'd3);
    repeat (5) tick;
    is_signed = 1'b1;
    dividend = 64'd50;
    divisor = 64'd5;
    start = 1'b1;
    tick;
    start = 1'b0;
    collect(got);
    exp = '{64'd333, 64'd1, 1'b0, NLAT - 6};
    check_res("ignore", got, exp);

    // start held high: second op accepted the cycle after done
    wait_idle;
    is_signed = 1'b0;
    dividend = 64'd77;
    divisor = 64'd5;
    start = 1'b1;
    tick;
    dividend = 64'd90;
    divisor = 64'd4;
    collect(got);
    exp = '{64'd15, 64'd2, 1'b0, NLAT};
    check_res("held_a", got, exp);
    n = 0;
    do begin
      tick;
      n++;
    end while (!done && n < 200);
    start = 1'b0;
    chk("held_b.gap", W'(n), W'(NLAT + 1));
    chk("held_b.q", quotient, 64'd22);
    chk("held_b.r", remainder, 64'd2);

    // reset in the middle of CALC aborts without done
    wait_idle;
    issue(1'b0, 64'd12345, 64'd7);
    repeat (3) tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk("abort.busy", W'(busy), '0);
    chk("abort.done", W'(done), '0);
    chk("abort.q", quotient, '0);
    chk("abort.r", remainder, '0);
    seen = 1'b0;
    repeat (80) begin
      tick;
      if (done) seen = 1'b1;
    end
    chk("abort.nodone", W'(seen), '0);
    issue(1'b0, ONES, 64'd1);
    collect(got);
    exp = '{ONES, 64'd0, 1'b0, NLAT};
    check_res("after_abort", got, exp);

    for (int i = 0; i < 1000; i++) begin
      logic         sgn;
      logic [W-1:0] a, b;
      int           mode;
      sgn = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      mode = $urandom_range(0, 9);
      if (mode == 0) b = '0;
      else if (mode == 1) begin
        a = MIN; b = ONES;
      end else if (mode == 2) b = W'($urandom_range(1, 15));
      else if (mode < 6) b = b >> $urandom_range(0, W - 1);
      if (mode == 3) b = -b;
      issue(sgn, a, b);
      collect(got);
      exp = model(sgn, a, b);
      check_res($sformatf("rnd%0d", i), got, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
